// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter level path and the VGA bar renderer.
package vu_pkg;

  // Width of one audio level sample and of the committed bar level.
  localparam int LEVEL_W = 8;

  // Colour byte layout shared with the renderer: RRR GGG BB.
  localparam int COLOR_R_W   = 3;
  localparam int COLOR_G_W   = 3;
  localparam int COLOR_B_W   = 2;
  localparam int COLOR_R_LSB = COLOR_G_W + COLOR_B_W;
  localparam int COLOR_G_LSB = COLOR_B_W;
  localparam int COLOR_B_LSB = 0;

  // Frame controller states.
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    ACCUM     = 2'd1,
    LATCH     = 2'd2,
    PEAK      = 2'd3
  } state_t;

  typedef logic [LEVEL_W-1:0] level_t;

  // Unsigned maximum of two levels.
  function automatic level_t level_max(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold marker: latches new peaks, holds them for HOLD_FRAMES updates,
// then decays by one LSB every DECAY_FRAMES updates without dropping below
// the current level.
module vu_peak_hold
  import vu_pkg::*;
#(
  parameter int HOLD_FRAMES  = 30,
  parameter int DECAY_FRAMES = 2
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               update,
  input  logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] peak
);

  localparam int HOLD_W  = cnt_width(HOLD_FRAMES + 1);
  localparam int DECAY_W = cnt_width(DECAY_FRAMES);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_FRAMES);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_FRAMES - 1);

  logic [HOLD_W-1:0]  hold_cnt;
  logic [DECAY_W-1:0] decay_cnt;
  level_t             peak_minus;
  level_t             peak_floor;

  // One-LSB decay candidate, floored at the current level and at zero.
  always_comb begin
    peak_minus = peak - level_t'(1);
    peak_floor = peak_minus;
    if ((peak == '0) || (peak_minus < level)) begin
      peak_floor = level;
    end
  end

  // Peak, hold and decay counters advance once per update strobe.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      peak      <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
    end else if (update) begin
      if (level >= peak) begin
        peak      <= level;
        hold_cnt  <= HOLD_INIT;
        decay_cnt <= '0;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else if (decay_cnt == DECAY_LAST) begin
        decay_cnt <= '0;
        peak      <= peak_floor;
      end else begin
        decay_cnt <= decay_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vu_frame_ctrl.sv
// Frame-synchronous level controller: collects the per-frame maximum of the
// incoming samples and commits it to the bar renderer at each v_sync start.
module vu_frame_ctrl
  import vu_pkg::*;
#(
  parameter int   HOLD_FRAMES  = 30,
  parameter int   DECAY_FRAMES = 2,
  parameter logic V_POL        = 1'b0
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               level_valid,
  output logic               level_ready,
  input  logic               v_sync,
  output logic [LEVEL_W-1:0] data,
  output logic [LEVEL_W-1:0] peak,
  output logic               frame_tick
);

  state_t state;
  state_t state_next;
  logic   vs_q;
  logic   frame_edge;
  logic   xfer;
  level_t acc;
  logic   ready_next;
  logic   tick_next;
  logic   peak_update;

  // v_sync history for start-of-pulse detection.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      vs_q <= ~V_POL;
    end else begin
      vs_q <= v_sync;
    end
  end

  // First cycle of the sync pulse, and a completed handshake.
  always_comb begin
    frame_edge = (v_sync == V_POL) && (vs_q != V_POL);
    xfer       = level_valid && level_ready;
  end

  // FSM state register.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; edges during LATCH/PEAK are ignored.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC, ACCUM: if (frame_edge) state_next = LATCH;
      LATCH:            state_next = PEAK;
      PEAK:             state_next = ACCUM;
      default:          state_next = WAIT_SYNC;
    endcase
  end

  // FSM outputs, decoded from the next state so the registered versions
  // line up with the state they belong to.
  always_comb begin
    ready_next  = (state_next == WAIT_SYNC) || (state_next == ACCUM);
    tick_next   = (state_next == PEAK);
    peak_update = (state == LATCH);
  end

  // Registered handshake and frame tick outputs.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      level_ready <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      level_ready <= ready_next;
      frame_tick  <= tick_next;
    end
  end

  // Running frame maximum and committed bar level. A sample accepted on the
  // edge cycle lands in acc before LATCH reads it, so it joins this frame.
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      acc  <= '0;
      data <= '0;
    end else if (state == LATCH) begin
      data <= acc;
      acc  <= '0;
    end else if (xfer) begin
      acc <= level_max(acc, level_in);
    end
  end

  // The peak marker is evaluated on the same edge that commits data, so in
  // the frame_tick cycle both bar and marker reflect the new frame.
  vu_peak_hold #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .DECAY_FRAMES(DECAY_FRAMES)
  ) u_peak_hold (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .update     (peak_update),
    .level      (acc),
    .peak       (peak)
  );

endmodule

// File: tb/tb_vu_frame_ctrl.sv
// Bench for vu_frame_ctrl: per-cycle reference model plus frame vectors and
// hand-written corner sequences.
module tb_vu_frame_ctrl;

  localparam int   HOLD  = 2;
  localparam int   DECAY = 2;
  localparam logic VP    = 1'b0;

  logic       pixel_clock = 1'b0;
  logic       reset       = 1'b0;
  logic [7:0] level_in    = 8'h00;
  logic       level_valid = 1'b0;
  logic       level_ready;
  logic       v_sync      = ~VP;
  logic [7:0] data;
  logic [7:0] peak;
  logic       frame_tick;

  vu_frame_ctrl #(
    .HOLD_FRAMES (HOLD),
    .DECAY_FRAMES(DECAY),
    .V_POL       (VP)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .level_in   (level_in),
    .level_valid(level_valid),
    .level_ready(level_ready),
    .v_sync     (v_sync),
    .data       (data),
    .peak       (peak),
    .frame_tick (frame_tick)
  );

  always #5 pixel_clock = ~pixel_clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected outputs after the next rising edge.
  bit         m_valid = 0;
  logic [7:0] m_data, m_peak;
  bit         m_ready, m_tick;
  logic       m_vs_prev;
  int         m_frame_max, m_cd, m_commit, m_hold, m_dc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_peak(input int lvl);
    if (lvl >= m_peak) begin
      m_peak = 8'(lvl);
      m_hold = HOLD;
      m_dc   = 0;
    end else if (m_hold != 0) begin
      m_hold = m_hold - 1;
    end else if (m_dc == DECAY - 1) begin
      m_dc   = 0;
      m_peak = 8'((int'(m_peak) - 1 < lvl) ? lvl : int'(m_peak) - 1);
    end else begin
      m_dc = m_dc + 1;
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] l, input bit vs, input bit rn);
    bit xfer, edge_now;
    if (!rn) begin
      m_valid = 1; m_data = 0; m_peak = 0; m_ready = 0; m_tick = 0;
      m_vs_prev = ~VP; m_frame_max = 0; m_cd = 0; m_hold = 0; m_dc = 0;
      return;
    end
    xfer      = v && m_ready;
    edge_now  = (vs == VP) && (m_vs_prev != VP);
    m_vs_prev = vs;
    if (xfer && (int'(l) > m_frame_max)) m_frame_max = int'(l);
    if (m_cd == 2) begin
      m_cd = 1; m_data = 8'(m_commit); model_peak(m_commit); m_tick = 1; m_ready = 0;
    end else if (m_cd == 1) begin
      m_cd = 0; m_tick = 0; m_ready = 1;
    end else if (edge_now) begin
      m_cd = 2; m_commit = m_frame_max; m_frame_max = 0; m_tick = 0; m_ready = 0;
    end else begin
      m_tick = 0; m_ready = 1;
    end
  endtask

  // One clock: compare current outputs with the model, drive, advance.
  task automatic cycle(input bit v, input logic [7:0] l, input bit vs, input bit rn);
    if (m_valid) begin
      check("model ready", level_ready, m_ready);
      check("model tick", frame_tick, m_tick);
      check("model data", data, m_data);
      check("model peak", peak, m_peak);
    end
    level_valid = v; level_in = l; v_sync = vs; reset = rn;
    model_step(v, l, vs, rn);
    @(negedge pixel_clock);
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b1, 8'hFF, ~VP, 1'b0);
  endtask

  // Idle cycle, optional sample, then sync edge + latch; returns with the
  // committed data visible.
  task automatic run_frame(input bit has, input logic [7:0] lvl);
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    if (has) cycle(1'b1, lvl, ~VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
  endtask

  typedef struct {
    bit         rst_first;
    logic [7:0] lvl;
    logic [7:0] exp_data;
    logic [7:0] exp_peak;
  } frame_vec_t;

  frame_vec_t vecs[15];

  initial begin
    int stalls;
    bit got;
    int gap;

    // Peak hold/decay and decay floor vectors.
    vecs[0]  = '{1'b1, 8'h50, 8'h50, 8'h50};
    vecs[1]  = '{1'b0, 8'h10, 8'h10, 8'h50};
    vecs[2]  = '{1'b0, 8'h10, 8'h10, 8'h50};
    vecs[3]  = '{1'b0, 8'h10, 8'h10, 8'h50};
    vecs[4]  = '{1'b0, 8'h10, 8'h10, 8'h4F};
    vecs[5]  = '{1'b0, 8'h10, 8'h10, 8'h4F};
    vecs[6]  = '{1'b0, 8'h10, 8'h10, 8'h4E};
    vecs[7]  = '{1'b0, 8'h10, 8'h10, 8'h4E};
    vecs[8]  = '{1'b1, 8'h12, 8'h12, 8'h12};
    vecs[9]  = '{1'b0, 8'h11, 8'h11, 8'h12};
    vecs[10] = '{1'b0, 8'h11, 8'h11, 8'h12};
    vecs[11] = '{1'b0, 8'h11, 8'h11, 8'h12};
    vecs[12] = '{1'b0, 8'h11, 8'h11, 8'h11};
    vecs[13] = '{1'b0, 8'h11, 8'h11, 8'h11};
    vecs[14] = '{1'b0, 8'h11, 8'h11, 8'h11};

    // Reset held with a valid 0xFF sample pending.
    do_reset(3);
    check("reset data", data, 8'h00);
    check("reset peak", peak, 8'h00);
    check("reset ready", level_ready, 1'b0);
    check("reset tick", frame_tick, 1'b0);
    cycle(1'b1, 8'hFF, ~VP, 1'b1);
    run_frame(1'b1, 8'h05);
    check("post-reset data", data, 8'h05);

    // Max capture within one frame.
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    cycle(1'b1, 8'h10, ~VP, 1'b1);
    cycle(1'b1, 8'h40, ~VP, 1'b1);
    cycle(1'b1, 8'h25, ~VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    check("max data", data, 8'h40);
    check("max peak", peak, 8'h40);
    check("max tick", frame_tick, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    check("max tick end", frame_tick, 1'b0);

    // Sample offered on the edge cycle joins the frame being committed.
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    cycle(1'b1, 8'h7F, VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    check("edge sample data", data, 8'h7F);
    run_frame(1'b0, 8'h00);
    check("empty frame data", data, 8'h00);

    // Sample offered just after the edge stalls two cycles, lands next frame.
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    cycle(1'b0, 8'h00, VP, 1'b1);
    stalls = 0;
    got    = 0;
    for (int i = 0; i < 8; i++) begin
      bit rdy;
      rdy = level_ready;
      if (!rdy) stalls++;
      cycle(1'b1, 8'h7F, VP, 1'b1);
      if (rdy) begin
        got = 1;
        break;
      end
    end
    check("stall cycles", stalls, 2);
    check("stall accepted", got, 1'b1);
    check("stalled frame data", data, 8'h00);
    run_frame(1'b0, 8'h00);
    check("stall next data", data, 8'h7F);

    // Frame vector table.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst_first) do_reset(2);
      run_frame(1'b1, vecs[i].lvl);
      check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d peak", i), peak, vecs[i].exp_peak);
      check($sformatf("vec%0d tick", i), frame_tick, 1'b1);
    end

    // Reset in the middle of an accumulating frame.
    do_reset(2);
    run_frame(1'b1, 8'h60);
    cycle(1'b0, 8'h00, ~VP, 1'b1);
    cycle(1'b1, 8'h60, ~VP, 1'b1);
    check("midrst pre peak", peak, 8'h60);
    cycle(1'b0, 8'h00, ~VP, 1'b0);
    check("midrst data", data, 8'h00);
    check("midrst peak", peak, 8'h00);
    check("midrst ready", level_ready, 1'b0);
    check("midrst tick", frame_tick, 1'b0);
    run_frame(1'b0, 8'h00);
    check("midrst frame data", data, 8'h00);
    check("midrst frame peak", peak, 8'h00);

    // Randomized traffic against the model.
    do_reset(2);
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      bit vs;
      bit rn;
      if (gap == 0) gap = $urandom_range(6, 30);
      gap--;
      vs = (gap < 3) ? VP : ~VP;
      rn = ($urandom_range(0, 499) != 0);
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), vs, rn);
    end
    cycle(1'b0, 8'h00, ~VP, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vu_frame_ctrl.md
Name: vu_frame_ctrl

Overview:
Frame-synchronous level controller that feeds the `data` byte of the VGA bar renderer.
- Accepts audio level samples through a valid/ready handshake and keeps the per-frame maximum.
- Commits that maximum to the renderer only at the start of each vertical sync pulse, so a bar never tears mid-frame.
- Maintains a peak-hold marker with configurable hold time and decay rate.

Parameters:
HOLD_FRAMES, 30, frames the peak marker is held after a new peak before decay starts (>=0)
DECAY_FRAMES, 2, frames between successive 1-LSB peak decrements (>=1)
V_POL, 0, active level of v_sync; must match the VGA timing generator's V_POL

Ports:
pixel_clock  in   1  single clock, shared with the VGA timing generator
reset        in   1  synchronous, active-low reset
level_in     in   8  unsigned audio level sample
level_valid  in   1  level_in is valid this cycle
level_ready  out  1  controller accepts a sample this cycle
v_sync       in   1  vertical sync from the VGA timing generator
data         out  8  committed bar level, drives VGA data
peak         out  8  peak-hold level for marker drawing
frame_tick   out  1  one-cycle pulse when data/peak have been updated

Behaviour:
- Reset is active when reset==0 at a pixel_clock rising edge. It is synchronous, so reset mid-operation clears everything on the next edge:
  - data=0, peak=0, frame_tick=0, level_ready=0
  - acc=0, hold_cnt=0, decay_cnt=0
  - state=WAIT_SYNC
  - v_sync history register = inactive (~V_POL)
- Frame edge: v_sync is registered once into vs_q. frame_edge = (v_sync==V_POL) && (vs_q!=V_POL), i.e. the first cycle of the sync pulse.
- Handshake: a sample transfers when level_valid && level_ready. level_ready is a registered output:
  - 1 in WAIT_SYNC and ACCUM;
  - 0 in LATCH and PEAK.
  - A producer holding valid keeps the sample until ready returns; no sample is lost or duplicated.
- Accumulator: on each transfer, acc <= max(acc, level_in).
- States:
  - WAIT_SYNC: first state after reset. Samples are accepted and accumulated. frame_edge -> LATCH.
  - ACCUM: samples are accepted. frame_edge -> LATCH. A transfer in the same cycle as frame_edge is folded into acc before the latch: LATCH uses max(acc, level_in).
  - LATCH (1 cycle): data <= acc; acc <= 0. -> PEAK.
  - PEAK (1 cycle): apply the peak rules below to the new data; frame_tick=1 for exactly this cycle (registered, so visible the cycle after PEAK is entered). -> ACCUM.
- Peak rules, evaluated against the new data in PEAK:
  - if data >= peak: peak <= data; hold_cnt <= HOLD_FRAMES; decay_cnt <= 0.
  - else if hold_cnt != 0: hold_cnt <= hold_cnt - 1.
  - else: decay_cnt <= decay_cnt + 1. When decay_cnt reaches DECAY_FRAMES-1, decay_cnt <= 0 and peak <= peak - 1, floored at data (peak never drops below data and never wraps below 0).
- Latency:
  - sample to data: committed at the next frame edge, plus 2 cycles;
  - frame_edge to data valid: 2 cycles;
  - frame_edge to frame_tick: 2 cycles.
- frame_edge seen while in LATCH or PEAK is ignored; this is legal only for degenerate timing.
- Widths:
  - acc and peak are 8 bits; max/compare is unsigned; no overflow is possible.
  - hold_cnt is $clog2(HOLD_FRAMES+1) bits, minimum 1.
  - decay_cnt is $clog2(DECAY_FRAMES) bits, minimum 1.
- A frame with no samples commits data=0.

Decomposition:
- Shared package vu_pkg:
  - state encoding (WAIT_SYNC, ACCUM, LATCH, PEAK; 2-bit);
  - LEVEL_W=8 constant;
  - color-byte field constants (R 3, G 3, B 2) shared with the renderer.
- One natural sub-module: vu_peak_hold. It holds peak, hold_cnt and decay_cnt, is enabled by a one-cycle update strobe, and takes the new level as input. The FSM, handshake and accumulator stay in vu_frame_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles with level_valid=1 and level_in=8'hFF -> data=0, peak=0, level_ready=0, frame_tick=0; the first frame after release commits only samples sent after release.
- Max capture: in one frame send 8'h10, 8'h40, 8'h25, then a v_sync pulse (V_POL=0) -> 2 cycles after the falling v_sync edge data=8'h40, peak=8'h40, frame_tick high for 1 cycle.
- Handshake stall: hold level_valid=1 with level_in=8'h7F across a frame edge -> level_ready low for exactly 2 cycles. The sample is counted once: in the frame being committed if it transferred on the edge cycle, otherwise in the next frame. Check against a scoreboard.
- Peak hold/decay (HOLD_FRAMES=2, DECAY_FRAMES=2): frame levels 8'h50, then 8'h10 repeated -> peak = 50, 50, 50, 50, 4F, 4F, 4E, ...; data=10 from the second frame on.
- Decay floor: peak=8'h12 with level held at 8'h11 -> peak decays to 8'h11 and stays; it never goes below data.
- Reset mid-frame: assert reset during ACCUM with acc=8'h60 and peak=8'h60 -> all outputs 0 next cycle, state WAIT_SYNC; the next frame with no samples commits data=0.
